// File: rtl/bounce_physics_core.sv
// bounce_physics_core: time-multiplexed fixed-point simulator of N_BALLS bouncing balls
// driving a merged LED bar and a registered per-ball position/velocity readout.
module bounce_physics_core #(
  parameter int WIDTH = 32,
  parameter int FRAC = 24,
  parameter int N_BALLS = 4,
  parameter int N_LEDS = 10,
  parameter int LED_STEP = 1677721,
  parameter int GRAVITY = 3355,
  parameter int VEL_SHIFT = 16,
  parameter int REST_SHIFT = 2,
  parameter int CEIL_INT = 10,
  parameter logic [WIDTH-1:0] KICK = 32'h03000000,
  parameter int FLOOR_POP = 256,
  parameter int RESET_POS = 1000,
  parameter logic [WIDTH-1:0] RESET_VEL = 32'h03000000,
  localparam int IW = N_BALLS > 1 ? $clog2(N_BALLS) : 1
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             tick,
  input  logic [N_BALLS-1:0] kick,
  input  logic             load_en,
  input  logic [IW-1:0]    load_idx,
  input  logic [WIDTH-1:0] load_pos,
  input  logic [WIDTH-1:0] load_vel,
  input  logic [IW-1:0]    sel,
  output logic [WIDTH-1:0] sel_pos,
  output logic [WIDTH-1:0] sel_vel,
  output logic [N_LEDS-1:0] led_bar,
  output logic             busy,
  output logic             frame_done,
  output logic             tick_overrun
);
  localparam int SW = N_LEDS > 1 ? $clog2(N_LEDS) : 1;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic parity_q, parity_d, ovr_q, ovr_d;
  logic [N_BALLS-1:0] pend_q, pend_d;
  logic [N_LEDS-1:0] led_acc_q, led_acc_d, led_q, led_d, led_one;
  logic signed [WIDTH-1:0] pos_q [N_BALLS];
  logic signed [WIDTH-1:0] pos_d [N_BALLS];
  logic signed [WIDTH-1:0] vel_q [N_BALLS];
  logic signed [WIDTH-1:0] vel_d [N_BALLS];
  logic [WIDTH-1:0] sel_pos_q, sel_pos_d, sel_vel_q, sel_vel_d;
  logic signed [WIDTH-1:0] p, v, vk, vg, pn, vr, p_new, v_new;
  logic [WIDTH:0] ksum;
  logic floor_hit, ceil_hit;
  logic [SW-1:0] seg;
  always_comb begin
    p = pos_q[idx_q];
    v = vel_q[idx_q];
    ksum = {v[WIDTH-1], v} + {KICK[WIDTH-1], KICK};
    vk = pend_q[idx_q] ? (v[WIDTH-1] ? KICK : (ksum[WIDTH] != ksum[WIDTH-1] ? MAXV : ksum[WIDTH-1:0])) : v;
    vg = vk - WIDTH'(GRAVITY) - WIDTH'(parity_q);
    pn = p + (v >>> VEL_SHIFT);
    vr = v - (v >>> REST_SHIFT);
    floor_hit = (p <= 0) && v[WIDTH-1];
    ceil_hit = ($signed(p[WIDTH-1:FRAC]) >= CEIL_INT) && (v > 0);
    v_new = floor_hit ? -vr : ceil_hit ? -v : vg;
    p_new = floor_hit ? WIDTH'(FLOOR_POP) : ceil_hit ? {(WIDTH-FRAC)'(CEIL_INT-1), p[FRAC-1:0]} : (pn[WIDTH-1] ? '0 : pn);
    // thresholds are monotonic, so the last one cleared is the segment
    seg = '0;
    for (int k = 1; k < N_LEDS; k++) seg = (p_new >= WIDTH'(k * LED_STEP)) ? SW'(k) : seg;
    led_one = N_LEDS'(1) << seg;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    parity_d = parity_q;
    led_acc_d = led_acc_q;
    led_d = led_q;
    ovr_d = ovr_q | (tick & (state_q != IDLE));
    pend_d = pend_q | kick;
    pos_d = pos_q;
    vel_d = vel_q;
    sel_pos_d = sel < N_BALLS ? pos_q[sel] : '0;
    sel_vel_d = sel < N_BALLS ? vel_q[sel] : '0;
    if (state_q == IDLE) begin
      if (load_en && load_idx < N_BALLS) begin
        pos_d[load_idx] = load_pos;
        vel_d[load_idx] = load_vel;
        pend_d[load_idx] = kick[load_idx];
      end
      if (tick) begin
        state_d = CALC;
        idx_d = '0;
        led_acc_d = '0;
      end
    end else if (state_q == CALC) begin
      pos_d[idx_q] = p_new;
      vel_d[idx_q] = v_new;
      pend_d[idx_q] = kick[idx_q];
      led_acc_d = led_acc_q | led_one;
      state_d = idx_q == IW'(N_BALLS - 1) ? DONE : CALC;
      idx_d = idx_q == IW'(N_BALLS - 1) ? idx_q : idx_q + 1'b1;
    end else begin
      led_d = led_acc_q;
      parity_d = ~parity_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      parity_q <= 1'b0;
      ovr_q <= 1'b0;
      pend_q <= '0;
      led_acc_q <= '0;
      led_q <= N_LEDS'(1);
      sel_pos_q <= WIDTH'(RESET_POS);
      sel_vel_q <= RESET_VEL;
      for (int i = 0; i < N_BALLS; i++) begin
        pos_q[i] <= WIDTH'(RESET_POS);
        vel_q[i] <= RESET_VEL;
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      parity_q <= parity_d;
      ovr_q <= ovr_d;
      pend_q <= pend_d;
      led_acc_q <= led_acc_d;
      led_q <= led_d;
      sel_pos_q <= sel_pos_d;
      sel_vel_q <= sel_vel_d;
      pos_q <= pos_d;
      vel_q <= vel_d;
    end
  end
  assign sel_pos = sel_pos_q;
  assign sel_vel = sel_vel_q;
  assign led_bar = led_q;
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign tick_overrun = ovr_q;
endmodule

// File: tb/tb_bounce_physics_core.sv
// tb_bounce_physics_core: directed vector table plus hand-written frame timing, kick,
// dither, overrun and mid-frame reset sequences.
module tb_bounce_physics_core;
  logic CLOCK_50 = 1'b0;
  logic Reset, tick, load_en;
  logic [3:0] kick;
  logic [1:0] load_idx, sel;
  logic [31:0] load_pos, load_vel, sel_pos, sel_vel;
  logic [9:0] led_bar;
  logic busy, frame_done, tick_overrun;
  int pass_cnt = 0;
  int total_cnt = 0;
  typedef struct {
    logic [1:0] idx;
    logic [31:0] p, v;
    logic kk;
    logic [31:0] ep, ev;
    logic [9:0] el;
  } vec_t;
  vec_t vecs[10];
  bounce_physics_core dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .tick(tick), .kick(kick),
    .load_en(load_en), .load_idx(load_idx), .load_pos(load_pos), .load_vel(load_vel),
    .sel(sel), .sel_pos(sel_pos), .sel_vel(sel_vel), .led_bar(led_bar),
    .busy(busy), .frame_done(frame_done), .tick_overrun(tick_overrun)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic do_reset();
    Reset = 1'b1;
    tick = 1'b0;
    kick = '0;
    load_en = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask
  task automatic load(input logic [1:0] idx, input logic [31:0] p, input logic [31:0] v);
    load_en = 1'b1;
    load_idx = idx;
    load_pos = p;
    load_vel = v;
    step();
    load_en = 1'b0;
  endtask
  task automatic wait_frame();
    int n = 0;
    while (!frame_done && n < 20) begin
      step();
      n++;
    end
    check("frame_done_seen", {31'b0, frame_done}, 32'd1);
  endtask
  task automatic run_frame();
    tick = 1'b1;
    step();
    tick = 1'b0;
    wait_frame();
    step();
    step();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int fd_cnt;
    vecs[0] = '{2'd1, 32'h00000000, 32'hFF000000, 1'b0, 32'h00000100, 32'h00C00000, 10'h001};
    vecs[1] = '{2'd2, 32'h0A000000, 32'h00100000, 1'b0, 32'h09000000, 32'hFFF00000, 10'h201};
    vecs[2] = '{2'd3, 32'h02000000, 32'hFFB00000, 1'b1, 32'h01FFFFB0, 32'h02FFF2E5, 10'h201};
    vecs[3] = '{2'd0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 32'hFFFFF2E5, 10'h001};
    vecs[4] = '{2'd1, 32'h00500000, 32'h7FFFFFFF, 1'b1, 32'h00507FFF, 32'h7FFFF2E4, 10'h009};
    vecs[5] = '{2'd2, 32'hFFFFFFFB, 32'h00010000, 1'b0, 32'h00000000, 32'h0000F2E5, 10'h001};
    vecs[6] = '{2'd3, 32'h0A000000, 32'hFFF00000, 1'b0, 32'h09FFFFF0, 32'hFFEFF2E5, 10'h201};
    vecs[7] = '{2'd0, 32'h00199999, 32'h00000000, 1'b0, 32'h00199999, 32'hFFFFF2E5, 10'h003};
    vecs[8] = '{2'd0, 32'h00199998, 32'h00000000, 1'b0, 32'h00199998, 32'hFFFFF2E5, 10'h001};
    vecs[9] = '{2'd1, 32'h09FFFFFF, 32'h00100000, 1'b0, 32'h0A00000F, 32'h000FF2E5, 10'h201};
    sel = 2'd0;
    load_idx = '0;
    load_pos = '0;
    load_vel = '0;
    do_reset();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    check("rst_overrun", {31'b0, tick_overrun}, 32'd0);
    check("rst_led", {22'b0, led_bar}, 32'h001);
    check("rst_sel_pos", sel_pos, 32'd1000);
    check("rst_sel_vel", sel_vel, 32'h03000000);
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("busy_c%0d", c), {31'b0, busy}, {31'b0, c <= 5});
      check($sformatf("fdone_c%0d", c), {31'b0, frame_done}, {31'b0, c == 5});
      step();
    end
    check("first_pos", sel_pos, 32'd1768);
    check("first_vel", sel_vel, 32'h02FFF2E5);
    check("first_led", {22'b0, led_bar}, 32'h001);
    for (int i = 0; i < 10; i++) begin
      do_reset();
      sel = vecs[i].idx;
      load(vecs[i].idx, vecs[i].p, vecs[i].v);
      if (vecs[i].kk) begin
        kick = 4'b0001 << vecs[i].idx;
        step();
        kick = '0;
      end
      run_frame();
      check($sformatf("vec%0d_pos", i), sel_pos, vecs[i].ep);
      check($sformatf("vec%0d_vel", i), sel_vel, vecs[i].ev);
      check($sformatf("vec%0d_led", i), {22'b0, led_bar}, {22'b0, vecs[i].el});
    end
    do_reset();
    sel = 2'd0;
    load(2'd0, 32'h02000000, 32'h01000000);
    run_frame();
    check("dither1_pos", sel_pos, 32'h02000100);
    check("dither1_vel", sel_vel, 32'h00FFF2E5);
    run_frame();
    check("dither2_pos", sel_pos, 32'h020001FF);
    check("dither2_vel", sel_vel, 32'h00FFE5C9);
    do_reset();
    sel = 2'd0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    kick = 4'b0001;
    step();
    kick = '0;
    wait_frame();
    step();
    step();
    check("kick_late_vel", sel_vel, 32'h02FFF2E5);
    run_frame();
    check("kick_next_pos", sel_pos, 32'd2535);
    check("kick_next_vel", sel_vel, 32'h05FFE5C9);
    do_reset();
    sel = 2'd1;
    kick = 4'b0010;
    step();
    kick = '0;
    load(2'd1, 32'h02000000, 32'h01000000);
    run_frame();
    check("load_clr_pos", sel_pos, 32'h02000100);
    check("load_clr_vel", sel_vel, 32'h00FFF2E5);
    do_reset();
    sel = 2'd2;
    load(2'd2, 32'h09000000, 32'h00000000);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    fd_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (frame_done) fd_cnt++;
      step();
    end
    check("ovr_frames", fd_cnt, 32'd1);
    check("ovr_flag", {31'b0, tick_overrun}, 32'd1);
    check("ovr_idle", {31'b0, busy}, 32'd0);
    check("ovr_led", {22'b0, led_bar}, 32'h201);
    check("ovr_pos", sel_pos, 32'h09000000);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    #2;
    Reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_fdone", {31'b0, frame_done}, 32'd0);
    check("abort_overrun", {31'b0, tick_overrun}, 32'd0);
    check("abort_led", {22'b0, led_bar}, 32'h001);
    check("abort_sel_pos", sel_pos, 32'd1000);
    check("abort_sel_vel", sel_vel, 32'h03000000);
    step();
    Reset = 1'b0;
    fd_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (frame_done) fd_cnt++;
      step();
    end
    check("abort_no_frame", fd_cnt, 32'd0);
    check("abort_pos_after", sel_pos, 32'd1000);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bounce_physics_core.md
Name: bounce_physics_core

Overview:
Parametrised successor to the single-LED bouncing ball. It simulates N_BALLS independent balls in signed fixed point, with per-ball kick inputs, a host load port, configurable restitution, a ceiling and a dithered gravity term. Balls are updated one per cycle by a time-multiplexed FSM, triggered by an external time-step tick from the existing timer. The block drives a merged LED bar and a selectable position/velocity readout for the HEX displays.

Parameters:
WIDTH, 32, position/velocity word width (signed).
FRAC, 24, fraction bits (Q(WIDTH-FRAC).FRAC).
N_BALLS, 4, number of simulated balls (>=1).
N_LEDS, 10, LED bar width.
LED_STEP, 1677721, position span per LED segment.
GRAVITY, 3355, velocity decrement per tick (LSBs).
VEL_SHIFT, 16, position += velocity >>> VEL_SHIFT.
REST_SHIFT, 2, bounce loss = v >>> REST_SHIFT (2 gives 25%).
CEIL_INT, 10, ceiling in integer units.
KICK, 32'h03000000, kick velocity.
FLOOR_POP, 256, position after floor bounce.
RESET_POS, 1000, reset position of every ball.
RESET_VEL, 32'h03000000, reset velocity of every ball.

Ports:
CLOCK_50  in  1  system clock.
Reset  in  1  asynchronous, active-high reset.
tick  in  1  one-cycle time-step strobe.
kick  in  N_BALLS  one-cycle kick request per ball.
load_en  in  1  host write strobe.
load_idx  in  clog2(N_BALLS)  ball to write.
load_pos  in  WIDTH  position to write.
load_vel  in  WIDTH  velocity to write.
sel  in  clog2(N_BALLS)  readout ball select.
sel_pos  out  WIDTH  registered position of ball sel.
sel_vel  out  WIDTH  registered velocity of ball sel.
led_bar  out  N_LEDS  OR of each ball's one-hot segment.
busy  out  1  frame update in progress.
frame_done  out  1  one-cycle pulse at end of frame.
tick_overrun  out  1  sticky: tick arrived while busy.

Behaviour:
- Reset (asynchronous) sets:
  - all pos = RESET_POS; all vel = RESET_VEL.
  - kick_pend = 0; parity = 0; idx = 0; state IDLE.
  - busy = 0; frame_done = 0; tick_overrun = 0; led_bar = 1.
  - sel_pos/sel_vel = RESET_POS/RESET_VEL.
- kick[i] sets kick_pend[i] on any cycle. A pending kick is consumed and cleared at ball i's next CALC. A kick in the same cycle as that CALC stays pending for the next frame.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on tick: idx = 0, busy = 1, led_acc = 0.
  - CALC: updates ball idx in one cycle. idx == N_BALLS-1 goes to DONE; otherwise idx++.
  - DONE: led_bar <= led_acc, frame_done = 1 for one cycle, parity toggles, busy = 0, then IDLE.
  - Frame latency is N_BALLS+1 cycles from tick to frame_done.
- tick while busy (CALC/DONE) is dropped and sets tick_overrun. tick_overrun clears only on Reset.
- load_en in IDLE writes pos/vel[load_idx] next cycle and clears kick_pend[load_idx]. load_en while busy is ignored. load_idx >= N_BALLS is ignored.
- CALC for ball i with old p, v (all arithmetic signed WIDTH; sat = clamp to signed max):
  - a) vk = pend ? (v < 0 ? KICK : sat(v + KICK)) : v.
  - b) vg = vk - (GRAVITY + parity).
  - c) pn = p + (v >>> VEL_SHIFT), using old v.
  - d) Floor, highest priority: if p <= 0 and v < 0, then v' = -(v - (v >>> REST_SHIFT)) and p' = FLOOR_POP.
  - e) Else ceiling: if p[WIDTH-1:FRAC] >= CEIL_INT and v > 0, then v' = -v and p' = {CEIL_INT-1, p[FRAC-1:0]}.
  - f) Else v' = vg and p' = (pn < 0 ? 0 : pn).
  - g) led_acc |= onehot(seg), where seg = p' < 0 ? 0 : min(p' / LED_STEP, N_LEDS-1). Implement as a compare chain against k*LED_STEP; no divider.
- sel_pos/sel_vel are registered every cycle from the ball array (1-cycle latency) and reflect writes the cycle after they land.
- Reset mid-frame aborts the frame. No frame_done is emitted and all state returns to reset values.

Test Plan:
- Reset, one tick -> ball0 pos = 1768 (0x6E8), vel = 0x02FFF2E5; frame_done pulses 5 cycles after tick; busy high for cycles 1-5.
- Floor: load ball1 pos = 0, vel = 0xFF000000, tick -> vel = 0x00C00000, pos = 0x100; led_bar bit0 set.
- Ceiling: load ball2 pos = 0x0A000000, vel = 0x00100000, tick -> vel = 0xFFF00000, pos = 0x09000000; led_bar bit9 set.
- Kick: load ball3 vel = 0xFFB00000, pos = 0x02000000, pulse kick[3], tick (parity 0) -> vel = 0x02FFF2E5, pos = 0x01FFFFB0.
- Dither: two ticks on a ball with vel 0x01000000 and no bounce -> vel = 0x01000000 - 3355 - 3356 = 0x00FFE5C9.
- Tick again 2 cycles after tick -> tick_overrun = 1 and only one frame_done. Assert Reset mid-frame -> all outputs at reset values, tick_overrun = 0.
